// File: rtl/seq_divider_if.sv
// Start/done handshake bundle for the sequential divider.
// The master drives operands and start; the slave returns status and results.
interface seq_divider_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic         signed_mode;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, signed or unsigned, N+1 cycle latency.
// Magnitudes are divided in CALC; signs and special cases are applied in FIX.
module seq_divider #(
  parameter int unsigned N = 8
) (
  input logic         clk,
  input logic         reset,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   work_q, work_d;
  logic [N-1:0]   dmag_q, dmag_d;
  logic [N-1:0]   dividend_q, dividend_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           div_zero_q, div_zero_d;
  logic           ovf_q, ovf_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           done_q, done_d;

  logic           dvd_neg, dvs_neg;
  logic [N-1:0]   dvd_mag, dvs_mag;
  logic [N:0]     shifted, trial;
  logic [N-1:0]   q_norm, r_norm;

  assign dvd_neg = bus.signed_mode & bus.dividend[N-1];
  assign dvs_neg = bus.signed_mode & bus.divisor[N-1];
  // -2^(N-1) negates to itself, which is the correct unsigned magnitude.
  assign dvd_mag = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvs_mag = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;

  assign shifted = {rem_q, work_q[N-1]};
  assign trial   = shifted - {1'b0, dmag_q};

  assign q_norm = qneg_q ? (~work_q + 1'b1) : work_q;
  assign r_norm = rneg_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    work_d      = work_q;
    dmag_d      = dmag_q;
    dividend_d  = dividend_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StCalc;
          cnt_d      = '0;
          rem_d      = '0;
          work_d     = dvd_mag;
          dmag_d     = dvs_mag;
          dividend_d = bus.dividend;
          qneg_d     = dvd_neg ^ dvs_neg;
          rneg_d     = dvd_neg;
          div_zero_d = (bus.divisor == '0);
          ovf_d      = bus.signed_mode && (bus.dividend == {1'b1, {(N-1){1'b0}}}) &&
                       (bus.divisor == '1);
        end
      end
      StCalc: begin
        if (!trial[N]) begin
          rem_d  = trial[N-1:0];
          work_d = {work_q[N-2:0], 1'b1};
        end else begin
          rem_d  = shifted[N-1:0];
          work_d = {work_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (div_zero_q) begin
          quotient_d  = '1;
          remainder_d = dividend_q;
        end else if (ovf_q) begin
          quotient_d  = dividend_q;
          remainder_d = '0;
        end else begin
          quotient_d  = q_norm;
          remainder_d = r_norm;
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      work_q      <= '0;
      dmag_q      <= '0;
      dividend_q  <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      work_q      <= work_d;
      dmag_q      <= dmag_d;
      dividend_q  <= dividend_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors push expected results and
// done timing; a monitor pops and compares on every done pulse.
module tb_seq_divider;
  localparam int unsigned N = 8;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    int           cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   n_done;
  int   n_expected;
  exp_t exp_q[$];

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", 32'(bus.quotient), 32'(e.q));
        chk("remainder", 32'(bus.remainder), 32'(e.r));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Present operands for one edge; expected done lands N+1 edges after acceptance.
  task automatic issue(input logic [N-1:0] dd, input logic [N-1:0] dv, input logic sm,
                       input logic [N-1:0] eq, input logic [N-1:0] er);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend    = dd;
    bus.divisor     = dv;
    bus.signed_mode = sm;
    @(posedge clk);
    #1;
    exp_q.push_back('{q: eq, r: er, cyc: cyc + int'(N) + 1});
    n_expected++;
    bus.start    = 1'b0;
    bus.dividend = 8'hA5;
    bus.divisor  = 8'h3C;
  endtask

  task automatic wait_idle(output int busy_cnt);
    bit ok;
    busy_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      busy_cnt++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy after 40 cycles expected idle");
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no done in 40 cycles expected done");
    end
  endtask

  task automatic run(input logic [N-1:0] dd, input logic [N-1:0] dv, input logic sm,
                     input logic [N-1:0] eq, input logic [N-1:0] er);
    int bc;
    issue(dd, dv, sm, eq, er);
    wait_idle(bc);
    chk("busy_cycles", bc, N + 1);
  endtask

  initial begin
    int bc;
    cyc             = 0;
    checks          = 0;
    errors          = 0;
    n_done          = 0;
    n_expected      = 0;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_quotient", 32'(bus.quotient), 0);
    chk("reset_remainder", 32'(bus.remainder), 0);
    @(negedge clk);
    reset = 1'b0;

    // Unsigned and signed arithmetic, divide by zero, signed overflow.
    run(8'd200, 8'd7,  1'b0, 8'd28,  8'd4);
    run(8'h9C,  8'd7,  1'b1, 8'hF2,  8'hFE);
    run(8'd100, 8'hF9, 1'b1, 8'hF2,  8'h02);
    run(8'h9C,  8'd7,  1'b0, 8'h16,  8'h02);
    run(8'h55,  8'h00, 1'b0, 8'hFF,  8'h55);
    run(8'h55,  8'h00, 1'b1, 8'hFF,  8'h55);
    run(8'h80,  8'hFF, 1'b1, 8'h80,  8'h00);
    run(8'h80,  8'hFF, 1'b0, 8'h00,  8'h80);
    run(8'hF9,  8'd2,  1'b1, 8'hFD,  8'hFF);
    run(8'hFF,  8'hFF, 1'b1, 8'h01,  8'h00);
    run(8'hFF,  8'd1,  1'b0, 8'hFF,  8'h00);
    run(8'd0,   8'd5,  1'b0, 8'h00,  8'h00);
    run(8'h80,  8'd3,  1'b1, 8'hD6,  8'hFE);

    // Start pulses while busy must be ignored.
    issue(8'd50, 8'd6, 1'b0, 8'd8, 8'd2);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(bc);
    repeat (12) @(negedge clk);

    // Start held in the done cycle is accepted.
    issue(8'd77, 8'd10, 1'b0, 8'd7, 8'd7);
    wait_done();
    bus.start = 1'b1; bus.dividend = 8'd250; bus.divisor = 8'd16; bus.signed_mode = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back('{q: 8'd15, r: 8'd10, cyc: cyc + int'(N) + 1});
    n_expected++;
    bus.start = 1'b0;
    wait_idle(bc);
    chk("b2b_busy_cycles", bc, N + 1);

    // Reset mid-operation aborts without a done pulse.
    issue(8'd123, 8'd4, 1'b0, 8'd30, 8'd3);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    n_expected--;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_quotient", 32'(bus.quotient), 0);
    chk("abort_remainder", 32'(bus.remainder), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    run(8'd123, 8'd4, 1'b0, 8'd30, 8'd3);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", n_done, n_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider; the inverse operation of the array multiplier in the signed/unsigned arithmetic group.
- Computes quotient and remainder of two N-bit operands over N+1 clock cycles, using a start/done handshake.
- A mode input selects two's-complement or unsigned division.
- Sits beside the multiplier in the datapath and shares its operand width and its signed/unsigned mode convention.

Parameters:
N, 8, operand/result width in bits (N >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement operands/results, 0 = unsigned
dividend  input  N  numerator, sampled with start
divisor  input  N  denominator, sampled with start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; quotient/remainder valid from this cycle
quotient  output  N  result quotient, held until next done
remainder  output  N  result remainder, held until next done

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state IDLE; busy=0, done=0, quotient=0, remainder=0; iteration counter=0.
  - Reset asserted mid-operation aborts the division; no done pulse is issued for it.
- States: IDLE, CALC, FIX.
- IDLE:
  - On edge with start=1, latch operands, mode and sign flags; go to CALC; busy=1.
  - Latched sign flags: sign_q = sign(dividend) XOR sign(divisor); sign_r = sign(dividend). Both flags are 0 when signed_mode=0.
  - Magnitudes: |dividend| and |divisor| when signed_mode=1, raw values otherwise. Magnitudes are N bits unsigned; -2^(N-1) maps to 2^(N-1).
- CALC (exactly N cycles, counter 0..N-1), per cycle:
  - Shift {partial_rem, work_q} left by one.
  - Trial subtract: partial_rem - divisor_mag, computed at N+1 bits.
  - If the result is non-negative, keep it and set the work_q LSB to 1; else restore and set the LSB to 0.
  - After the cycle with counter=N-1, go to FIX.
- FIX (1 cycle):
  - Apply signs: quotient = sign_q ? -work_q : work_q; remainder = sign_r ? -partial_rem : partial_rem.
  - Register the results, pulse done=1, busy=0, return to IDLE.
- Special cases are resolved in FIX and override the normal result:
  - divisor=0: quotient = all ones; remainder = original dividend.
  - signed_mode=1, dividend=-2^(N-1), divisor=-1: quotient = dividend; remainder = 0.
  - Special cases still take the full N+1 cycle latency. Latency is data-independent.
- Latency: start sampled at edge k; done=1 after edge k+N+1, for exactly one cycle.
- Handshake rules:
  - start while busy=1 is ignored; the operation in flight is unaffected.
  - start may be asserted in the done cycle; it is accepted because busy=0 there. Back-to-back throughput is one result per N+1 cycles.
  - Operand inputs are don't-care except at the accepting edge.
- Rounding: quotient truncates toward zero; remainder has the sign of the dividend, or is zero. dividend = quotient*divisor + remainder holds for all non-special cases.
- quotient and remainder change only in FIX; they are stable between done pulses.

Test Plan:
- Unsigned, N=8: start with dividend=200, divisor=7, signed_mode=0 -> done exactly 9 cycles after start edge; quotient=28, remainder=4; busy high 9 cycles.
- Signed, N=8: dividend=0x9C (-100), divisor=7 -> quotient=0xF2 (-14), remainder=0xFE (-2). Then dividend=100, divisor=0xF9 (-7) -> quotient=0xF2, remainder=0x02.
- Divide by zero: dividend=0x55, divisor=0, both modes -> quotient=0xFF, remainder=0x55, done after 9 cycles.
- Signed overflow: dividend=0x80, divisor=0xFF, signed_mode=1 -> quotient=0x80, remainder=0x00. Same operands with signed_mode=0 -> quotient=0x00, remainder=0x80.
- Handshake:
  - start pulsed at cycles 3 and 5 of a running op -> ignored, single done.
  - start held high in the done cycle -> second op accepted, second done 9 cycles later.
- Reset mid-op: assert reset at CALC cycle 4 -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse; a following start completes normally.
